// File: rtl/fp16_mean_feed.sv
// Sequential fp16 accumulator feeding the divider: sums a vector one element per
// four cycles, then presents sum and element count (as fp16) and handshakes the divider.
module fp16_mean_feed (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] sum_out,
    output logic [15:0] cnt_out,
    output logic        div_start,
    input  logic        div_done,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StIssue, StWait} state_e;

    state_e      state_q;
    logic [15:0] acc_q, opb_q;
    logic [10:0] cnt_q;
    logic        last_q;
    logic        sa_q, sb_q, sign_q;
    logic [10:0] ma_q, mb_q;
    logic [4:0]  exp_q;
    logic [11:0] sum_q;
    logic        in_ready_q, busy_q, div_start_q;
    logic [15:0] sum_out_q, cnt_out_q;

    // Exponent 31 becomes the largest finite value; exponent 0 becomes +0.
    function automatic logic [15:0] clamp_op(input logic [15:0] x);
        clamp_op = x;
        if (x[14:10] == 5'd31) begin
            clamp_op = {x[15], 15'h7BFF};
        end else if (x[14:10] == 5'd0) begin
            clamp_op = 16'h0000;
        end
    endfunction

    function automatic logic [15:0] cnt_to_fp16(input logic [10:0] c);
        logic [3:0] p;
        logic [4:0] e;
        logic [9:0] frac;
        p = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (c[i]) p = 4'(i);
        end
        e    = 5'd15 + {1'b0, p};
        frac = 10'(c << (4'd10 - p));
        cnt_to_fp16 = (c == 11'd0) ? 16'h0000 : {1'b0, e, frac};
    endfunction

    // Align stage
    logic [15:0] a_op, b_op;
    logic [4:0]  a_exp, b_exp, ediff, al_exp;
    logic [10:0] a_man, b_man, al_a, al_b;

    always_comb begin
        a_op  = clamp_op(acc_q);
        b_op  = clamp_op(opb_q);
        a_exp = a_op[14:10];
        b_exp = b_op[14:10];
        a_man = (a_exp == 5'd0) ? 11'd0 : {1'b1, a_op[9:0]};
        b_man = (b_exp == 5'd0) ? 11'd0 : {1'b1, b_op[9:0]};
        if (a_exp >= b_exp) begin
            ediff  = a_exp - b_exp;
            al_exp = a_exp;
            al_a   = a_man;
            al_b   = (ediff >= 5'd11) ? 11'd0 : (b_man >> ediff);
        end else begin
            ediff  = b_exp - a_exp;
            al_exp = b_exp;
            al_b   = b_man;
            al_a   = (ediff >= 5'd11) ? 11'd0 : (a_man >> ediff);
        end
    end

    // Add stage
    logic [11:0] add_sum;
    logic        add_sign;

    always_comb begin
        add_sum  = 12'd0;
        add_sign = 1'b0;
        if (sa_q == sb_q) begin
            add_sum  = {1'b0, ma_q} + {1'b0, mb_q};
            add_sign = sa_q;
        end else if (ma_q > mb_q) begin
            add_sum  = {1'b0, ma_q - mb_q};
            add_sign = sa_q;
        end else if (mb_q > ma_q) begin
            add_sum  = {1'b0, mb_q - ma_q};
            add_sign = sb_q;
        end
    end

    // Normalize stage
    logic [3:0]        lz;
    logic [9:0]        n_frac;
    logic signed [6:0] n_exp;
    logic [15:0]       norm_res;
    logic [10:0]       cnt_inc;

    always_comb begin
        lz = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (sum_q[i]) lz = 4'(10 - i);
        end
        if (sum_q[11]) begin
            n_frac = sum_q[10:1];
            n_exp  = $signed({2'b00, exp_q}) + 7'sd1;
        end else begin
            n_frac = 10'(sum_q[10:0] << lz);
            n_exp  = $signed({2'b00, exp_q}) - $signed({3'b000, lz});
        end
        if (sum_q == 12'd0 || n_exp < 7'sd1) begin
            norm_res = 16'h0000;
        end else if (n_exp > 7'sd30) begin
            norm_res = {sign_q, 15'h7BFF};
        end else begin
            norm_res = {sign_q, n_exp[4:0], n_frac};
        end
        cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= 16'h0000;
            opb_q       <= 16'h0000;
            cnt_q       <= 11'd0;
            last_q      <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            ma_q        <= 11'd0;
            mb_q        <= 11'd0;
            exp_q       <= 5'd0;
            sum_q       <= 12'd0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            sum_out_q   <= 16'h0000;
            cnt_out_q   <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        opb_q      <= in_data;
                        last_q     <= in_last;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StAlign;
                    end
                end
                StAlign: begin
                    sa_q    <= a_op[15];
                    sb_q    <= b_op[15];
                    ma_q    <= al_a;
                    mb_q    <= al_b;
                    exp_q   <= al_exp;
                    state_q <= StAdd;
                end
                StAdd: begin
                    sum_q   <= add_sum;
                    sign_q  <= add_sign;
                    state_q <= StNorm;
                end
                StNorm: begin
                    acc_q <= norm_res;
                    cnt_q <= cnt_inc;
                    if (last_q) begin
                        sum_out_q   <= norm_res;
                        cnt_out_q   <= cnt_to_fp16(cnt_inc);
                        div_start_q <= 1'b1;
                        state_q     <= StIssue;
                    end else begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StIssue: begin
                    div_start_q <= 1'b0;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (div_done) begin
                        acc_q      <= 16'h0000;
                        cnt_q      <= 11'd0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign div_start = div_start_q;
    assign sum_out   = sum_out_q;
    assign cnt_out   = cnt_out_q;

endmodule

// File: tb/tb_fp16_mean_feed.sv
// Directed bench for fp16_mean_feed: latency, arithmetic corner cases, divider
// handshake and mid-vector reset, with hand-computed expected values.
module tb_fp16_mean_feed;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] sum_out;
    logic [15:0] cnt_out;
    logic        div_start;
    logic        div_done = 1'b0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fp16_mean_feed dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sum_out   (sum_out),
        .cnt_out   (cnt_out),
        .div_start (div_start),
        .div_done  (div_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Vector table: first element, second element, two-element flag, expected sum/count.
    localparam logic [15:0] VA[10]   = '{16'h3C00, 16'h3C00, 16'h7BFF, 16'h4200, 16'h3C00,
                                         16'h4000, 16'hC000, 16'h7C00, 16'h0001, 16'hFC00};
    localparam logic [15:0] VB[10]   = '{16'hBC00, 16'h0C00, 16'h7BFF, 16'hC000, 16'h0001,
                                         16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 16'h0000};
    localparam logic        VP[10]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                         1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] VSUM[10] = '{16'h0000, 16'h3C00, 16'h7BFF, 16'h3C00, 16'h3C00,
                                         16'h4200, 16'hBC00, 16'h7BFF, 16'h0000, 16'hFBFF};
    localparam logic [15:0] VCNT[10] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000,
                                         16'h4000, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00};

    // Waits (bounded) for in_ready, presents one element for one edge, returns in cycle 1.
    task automatic send(input logic [15:0] d, input logic l);
        int t = 0;
        while (in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts cycles from cycle 1 after accept until div_start is seen (bounded).
    task automatic wait_start(output int k);
        k = 1;
        while (div_start !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic finish_div();
        @(negedge clk);
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, required 0", busy);
        end
        n_tests++;
        if (div_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_div_start: got %b, required 0", div_start);
        end
        n_tests++;
        if (sum_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sum_out: got %h, required 0000", sum_out);
        end
        n_tests++;
        if (cnt_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_cnt_out: got %h, required 0000", cnt_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        send(16'h3C00, 1'b1);
        wait_start(k);
        n_tests++;
        if (k !== 4 || div_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: div_start=%b at cycle %0d, required 1 at cycle 4",
                     div_start, k);
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL single_busy: got %b, required 1", busy);
        end
        n_tests++;
        if (sum_out !== 16'h3C00) begin
            n_fail++; $display("FAIL single_sum: got %h, required 3c00", sum_out);
        end
        n_tests++;
        if (cnt_out !== 16'h3C00) begin
            n_fail++; $display("FAIL single_cnt: got %h, required 3c00", cnt_out);
        end
        @(negedge clk);
        n_tests++;
        if (div_start !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse_width: div_start=%b in_ready=%b, required 0 0",
                     div_start, in_ready);
        end
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_three();
        int k;
        send(16'h3C00, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL three_ready_low c%0d: got %b, required 0", i, in_ready);
            end
            @(negedge clk);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL three_ready_back: got %b, required 1", in_ready);
        end
        send(16'h4000, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL three_ready_low2 c%0d: got %b, required 0", i, in_ready);
            end
            @(negedge clk);
        end
        send(16'h3800, 1'b1);
        wait_start(k);
        n_tests++;
        if (k !== 4) begin
            n_fail++; $display("FAIL three_latency: cycle %0d, required 4", k);
        end
        n_tests++;
        if (sum_out !== 16'h4300) begin
            n_fail++; $display("FAIL three_sum: got %h, required 4300", sum_out);
        end
        n_tests++;
        if (cnt_out !== 16'h4200) begin
            n_fail++; $display("FAIL three_cnt: got %h, required 4200", cnt_out);
        end
        finish_div();
    endtask

    task automatic test_arith();
        int k;
        for (int v = 0; v < 10; v++) begin
            if (VP[v]) begin
                send(VA[v], 1'b0);
                send(VB[v], 1'b1);
            end else begin
                send(VA[v], 1'b1);
            end
            wait_start(k);
            n_tests++;
            if (div_start !== 1'b1) begin
                n_fail++; $display("FAIL arith%0d_start: got %b, required 1", v, div_start);
            end
            n_tests++;
            if (sum_out !== VSUM[v]) begin
                n_fail++; $display("FAIL arith%0d_sum: got %h, required %h", v, sum_out, VSUM[v]);
            end
            n_tests++;
            if (cnt_out !== VCNT[v]) begin
                n_fail++; $display("FAIL arith%0d_cnt: got %h, required %h", v, cnt_out, VCNT[v]);
            end
            finish_div();
        end
    endtask

    task automatic test_hold();
        int k;
        int pulses = 0;
        int bad = 0;
        send(16'h4000, 1'b1);
        wait_start(k);
        for (int i = 0; i < 20; i++) begin
            if (div_start === 1'b1) pulses++;
            if (in_ready !== 1'b0 || sum_out !== 16'h4000 || cnt_out !== 16'h3C00) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL hold_pulses: got %0d, required 1", pulses);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
        end
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release: in_ready=%b, required 1", in_ready);
        end
        send(16'h3C00, 1'b1);
        wait_start(k);
        n_tests++;
        if (sum_out !== 16'h3C00 || cnt_out !== 16'h3C00) begin
            n_fail++;
            $display("FAIL hold_next_vector: sum=%h cnt=%h, required 3c00 3c00", sum_out, cnt_out);
        end
        finish_div();
    endtask

    task automatic test_reset_mid();
        int k;
        int pulses = 0;
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || div_start !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: in_ready=%b busy=%b div_start=%b, required 1 0 0",
                     in_ready, busy, div_start);
        end
        n_tests++;
        if (sum_out !== 16'h0000 || cnt_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_data: sum=%h cnt=%h, required 0000 0000", sum_out, cnt_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (div_start === 1'b1) pulses++;
            @(negedge clk);
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL midreset_no_start: got %0d pulses, required 0", pulses);
        end
        send(16'h4000, 1'b1);
        wait_start(k);
        n_tests++;
        if (k !== 4 || sum_out !== 16'h4000 || cnt_out !== 16'h3C00) begin
            n_fail++;
            $display("FAIL midreset_next: cycle=%0d sum=%h cnt=%h, required 4 4000 3c00",
                     k, sum_out, cnt_out);
        end
        finish_div();
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_arith();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
